uart_tx_core: RTL and testbench

Parametrised, FIFO-buffered UART transmit engine. It succeeds the fixed-format TX path inside uart_wrapper and sits between the AXI4-Lite register block (write side) and the txd pin. It adds run-time character length (5-8 bits), parity (none, even or odd), 1 or 2 stop bits, a run-time baud divisor, a configurable FIFO depth and an idle/empty interrupt.

---
 rtl/uart_tx_core.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_tx_core.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// uart_tx_core: FIFO-buffered UART transmitter with run-time character length,
// parity, stop bits and baud divisor, plus an idle/empty level interrupt.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high, waiting for a queued word and tx_enable
// START  | start bit (txd=0) for one bit period
// DATA   | 5..8 data bits, LSB first, one per bit period
// PARITY | parity bit (even/odd over the data bits)
// STOP1  | first stop bit (txd=1)
// STOP2  | optional second stop bit (txd=1)
module uart_tx_core #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]           data_bits,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop_two,
  input  logic                 tx_enable,
  input  logic                 irq_en,
  input  logic [7:0]           wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [CW-1:0]        fifo_count,
  output logic                 tx_busy,
  output logic                 irq,
  output logic                 txd
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  // FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // FSM and per-frame registers
  state_t                 state;
  state_t                 state_nxt;
  logic [7:0]             shreg;
  logic [DIV_WIDTH-1:0]   div_lat;
  logic [1:0]             bits_lat;
  logic                   pen_lat;
  logic                   podd_lat;
  logic                   s2_lat;
  logic                   par_acc;
  logic [2:0]             bit_idx;
  logic [DIV_WIDTH-1:0]   cnt;
  logic                   txd_r;
  logic                   txd_nxt;
  logic                   irq_r;
  logic                   shift_en;
  logic                   can_start;
  logic                   tc;
  logic                   last_bit;
  logic [DIV_WIDTH-1:0]   eff_div_in;

  assign wr_ready   = (count != CW'(FIFO_DEPTH));
  assign push       = wr_valid && wr_ready;
  assign fifo_count = count;
  assign tx_busy    = (state != S_IDLE);
  assign irq        = irq_r;
  assign txd        = txd_r;

  // Divisors below 2 would give a zero-length bit period; clamp them.
  assign eff_div_in = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baud_div;
  assign can_start  = (count != '0) && tx_enable;
  assign tc         = (cnt == '0);
  assign last_bit   = (bit_idx == (3'd4 + {1'b0, bits_lat}));

  // FIFO storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; a same-edge push and pop leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Next-state, pop request and next txd value.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    shift_en  = 1'b0;
    case (state)
      S_IDLE: begin
        if (can_start) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (tc) begin
          state_nxt = S_DATA;
          shift_en  = 1'b1;
        end
      end
      S_DATA: begin
        if (tc) begin
          if (last_bit) begin
            state_nxt = pen_lat ? S_PARITY : S_STOP1;
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tc) state_nxt = S_STOP1;
      end
      S_STOP1: begin
        if (tc) begin
          if (s2_lat) begin
            state_nxt = S_STOP2;
          end else if (can_start) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_STOP2: begin
        if (tc) begin
          if (can_start) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_START:  txd_nxt = 1'b0;
      S_DATA:   txd_nxt = shift_en ? shreg[0] : txd_r;
      S_PARITY: txd_nxt = par_acc ^ podd_lat;
      default:  txd_nxt = 1'b1;
    endcase
  end

  // State, line output and interrupt registers; txd idles high out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      txd_r <= 1'b1;
      irq_r <= 1'b0;
    end else begin
      state <= state_nxt;
      txd_r <= txd_nxt;
      irq_r <= irq_en && (count == '0) && (state == S_IDLE);
    end
  end

  // Frame datapath: config snapshot on pop, shift/parity per data bit, bit-period timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      div_lat  <= DIV_WIDTH'(2);
      bits_lat <= '0;
      pen_lat  <= 1'b0;
      podd_lat <= 1'b0;
      s2_lat   <= 1'b0;
      par_acc  <= 1'b0;
      bit_idx  <= '0;
      cnt      <= '0;
    end else begin
      if (pop) begin
        shreg    <= mem[rd_ptr];
        div_lat  <= eff_div_in;
        bits_lat <= data_bits;
        pen_lat  <= parity_en;
        podd_lat <= parity_odd;
        s2_lat   <= stop_two;
        par_acc  <= 1'b0;
        bit_idx  <= '0;
      end else if (shift_en) begin
        shreg   <= shreg >> 1;
        par_acc <= par_acc ^ shreg[0];
        bit_idx <= (state == S_START) ? 3'd0 : bit_idx + 3'd1;
      end

      if (pop) begin
        cnt <= eff_div_in - 1'b1;
      end else if (state != S_IDLE) begin
        if (tc) cnt <= div_lat - 1'b1;
        else    cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Testbench for uart_tx_core: frame-level reference model plus directed frames.
module tb_uart_tx_core;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic [1:0]  data_bits = 2'd3;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        stop_two = 1'b0;
  logic        tx_enable = 1'b0;
  logic        irq_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [4:0]  fifo_count;
  logic        tx_busy;
  logic        irq;
  logic        txd;

  int checks = 0;
  int failures = 0;
  bit run_cmp = 1'b0;

  uart_tx_core #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .data_bits(data_bits),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop_two(stop_two),
    .tx_enable(tx_enable), .irq_en(irq_en), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .fifo_count(fifo_count),
    .tx_busy(tx_busy), .irq(irq), .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of words, and a schedule of txd levels (one per cycle)
  int q[$];
  bit sched[$];
  bit m_txd = 1'b1;
  bit m_busy = 1'b0;
  bit m_irq = 1'b0;

  task automatic build_frame(input logic [7:0] d);
    int n;
    int dv;
    bit b[$];
    bit p;
    n  = 5 + int'(data_bits);
    dv = (baud_div < 16'd2) ? 2 : int'(baud_div);
    p  = parity_odd;
    b.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      b.push_back(d[i]);
      p = p ^ d[i];
    end
    if (parity_en) b.push_back(p);
    b.push_back(1'b1);
    if (stop_two) b.push_back(1'b1);
    foreach (b[k]) for (int j = 0; j < dv; j++) sched.push_back(b[k]);
  endtask

  initial begin
    int cb;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        sched.delete();
        m_txd = 1'b1;
        m_busy = 1'b0;
        m_irq = 1'b0;
      end else begin
        cb = q.size();
        m_irq = irq_en && (cb == 0) && !m_busy;
        if (sched.size() == 0 && cb != 0 && tx_enable) begin
          build_frame(8'(q.pop_front()));
        end
        if (wr_valid && cb != DEPTH) q.push_back(int'(wr_data));
        if (sched.size() != 0) begin
          m_txd = sched.pop_front();
          m_busy = 1'b1;
        end else begin
          m_txd = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (run_cmp && !rst) begin
        check("txd", 32'(txd), 32'(m_txd));
        check("tx_busy", 32'(tx_busy), 32'(m_busy));
        check("irq", 32'(irq), 32'(m_irq));
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
        check("wr_ready", 32'(wr_ready), 32'(q.size() != DEPTH));
      end
    end
  end

  task automatic run_frame(input string nm, input logic [15:0] dv, input logic [1:0] db,
                           input logic pe, input logic po, input logic s2, input logic [7:0] d,
                           input int deff, input logic [15:0] exp_bits, input int exp_len);
    int t;
    int len;
    logic [15:0] got;
    @(negedge clk);
    baud_div = dv; data_bits = db; parity_en = pe; parity_odd = po; stop_two = s2;
    irq_en = 1'b1; tx_enable = 1'b1;
    wr_valid = 1'b1; wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
    t = 0;
    while (txd !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_latency"}, 32'(t), 32'd1);
    got = '0;
    len = 0;
    while (tx_busy === 1'b1 && len < 400) begin
      if ((len % deff) == 0 && (len / deff) < 16) got[len / deff] = txd;
      len++;
      @(negedge clk);
    end
    check({nm, "_bits"}, 32'(got), 32'(exp_bits));
    check({nm, "_len"}, 32'(len), 32'(exp_len));
    check({nm, "_irq_lag"}, 32'(irq), 32'd0);
    @(negedge clk);
    check({nm, "_irq"}, 32'(irq), 32'd1);
  endtask

  task automatic drain(input string nm);
    int t;
    @(negedge clk);
    wr_valid = 1'b0;
    tx_enable = 1'b1;
    t = 0;
    while ((tx_busy === 1'b1 || fifo_count !== '0) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_drain_done"}, 32'(t < 4000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int len;
    int t;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd1);
    rst = 1'b0;
    run_cmp = 1'b1;
    repeat (2) @(negedge clk);

    // Hand-computed frames (bit k of the expected vector is the k-th bit on the line)
    run_frame("8n1_a5", 16'd4, 2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 4, 16'h034A, 40);
    run_frame("7e1_d5", 16'd3, 2'd2, 1'b1, 1'b0, 1'b0, 8'hD5, 3, 16'h02AA, 30);
    run_frame("7o1_d5", 16'd3, 2'd2, 1'b1, 1'b1, 1'b0, 8'hD5, 3, 16'h03AA, 30);
    run_frame("5o2_1f", 16'd0, 2'd0, 1'b1, 1'b1, 1'b1, 8'h1F, 2, 16'h01BE, 18);

    // Fill past capacity with transmission held off, then release
    @(negedge clk);
    tx_enable = 1'b0; baud_div = 16'd2; data_bits = 2'd3; parity_en = 1'b0; stop_two = 1'b0;
    irq_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'(i * 7 + 1);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("full_count", 32'(fifo_count), 32'd16);
    check("full_ready", 32'(wr_ready), 32'd0);
    tx_enable = 1'b1;
    @(negedge clk);
    len = 0;
    while (tx_busy === 1'b1 && len < 1000) begin
      len++;
      @(negedge clk);
    end
    check("b2b_len", 32'(len), 32'd320);
    check("b2b_irq_lag", 32'(irq), 32'd0);
    @(negedge clk);
    check("b2b_irq", 32'(irq), 32'd1);

    // Configuration change mid-frame only affects the following frame
    @(negedge clk);
    baud_div = 16'd4; data_bits = 2'd3; parity_en = 1'b0; stop_two = 1'b0; tx_enable = 1'b1;
    wr_valid = 1'b1; wr_data = 8'h3C;
    @(negedge clk);
    wr_valid = 1'b0;
    len = 0;
    t = 0;
    while (t < 400) begin
      @(negedge clk);
      t++;
      if (tx_busy === 1'b1) begin
        len++;
        if (len == 10) begin
          baud_div = 16'd8; data_bits = 2'd0;
          wr_valid = 1'b1; wr_data = 8'h0F;
        end else begin
          wr_valid = 1'b0;
        end
      end else if (len > 0) begin
        break;
      end
    end
    check("midcfg_len", 32'(len), 32'd96);

    // Reset in the middle of a data bit
    @(negedge clk);
    baud_div = 16'd4; data_bits = 2'd3; parity_en = 1'b0; stop_two = 1'b0; tx_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'h00;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_count", 32'(fifo_count), 32'd2);
    #1 rst = 1'b1;
    #1;
    check("async_rst_txd", 32'(txd), 32'd1);
    check("async_rst_count", 32'(fifo_count), 32'd0);
    check("async_rst_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_ready", 32'(wr_ready), 32'd1);
    repeat (20) @(negedge clk);
    check("post_rst_idle", 32'(txd), 32'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      wr_valid = ($urandom_range(0, 99) < 15);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 99) < 3) begin
        baud_div = 16'($urandom_range(0, 5));
        data_bits = 2'($urandom);
        parity_en = 1'($urandom);
        parity_odd = 1'($urandom);
        stop_two = 1'($urandom);
      end
      if ($urandom_range(0, 99) < 2) tx_enable = ~tx_enable;
      if ($urandom_range(0, 199) == 0) irq_en = ~irq_en;
    end
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
